// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operation sequencer: opcodes, FSM states, default width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXEC    = 2'b01,
    ST_MUL_RUN = 2'b10,
    ST_RESP    = 2'b11
  } alu_state_e;

endpackage

// File: rtl/booth_r2_core.sv
// Iterative signed Booth radix-2 multiplier: load on start, WIDTH steps, one-cycle done pulse.
module booth_r2_core #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m,
  input  logic [WIDTH-1:0]     q,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // A carries one extra bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
  logic [WIDTH:0]     acc_q;
  logic [WIDTH:0]     m_q;
  logic [WIDTH-1:0]   mq_q;
  logic               q_1;
  logic [CNT_W-1:0]   count;
  logic               running;

  logic [WIDTH:0]     acc_sum;
  logic [WIDTH:0]     acc_next;
  logic [WIDTH-1:0]   mq_next;

  always_comb begin
    acc_sum = acc_q;
    case ({mq_q[0], q_1})
      2'b01:   acc_sum = acc_q + m_q;
      2'b10:   acc_sum = acc_q - m_q;
      default: acc_sum = acc_q;
    endcase
    acc_next = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    mq_next  = {acc_sum[0], mq_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      m_q     <= '0;
      mq_q    <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc_q   <= '0;
        m_q     <= {m[WIDTH-1], m};
        mq_q    <= q;
        q_1     <= 1'b0;
        count   <= '0;
        running <= 1'b1;
      end else if (running) begin
        acc_q <= acc_next;
        mq_q  <= mq_next;
        q_1   <= mq_q[0];
        count <= count + CNT_W'(1);
        if (count == CNT_W'(WIDTH - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
          product <= {acc_next[WIDTH-1:0], mq_next};
        end
      end
    end
  end

endmodule

// File: rtl/ripple_carry_adder_8bit.sv
// 8-bit ripple-carry adder: sum = a + b + cin, cout is the carry out of bit 7.
module ripple_carry_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[8];

endmodule

// File: rtl/subtracter_8bit.sv
// 8-bit subtracter: diff = a - b computed as a + ~b + 1; borrow_n = 1 means no borrow.
module subtracter_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       borrow_n
);

  logic [7:0] b_inv;
  logic [8:0] c;

  assign b_inv = ~b;
  assign c[0]  = 1'b1;

  for (genvar i = 0; i < 8; i++) begin : g_fs
    assign diff[i] = a[i] ^ b_inv[i] ^ c[i];
    assign c[i+1]  = (a[i] & b_inv[i]) | (c[i] & (a[i] ^ b_inv[i]));
  end

  // Carry out of a + ~b + 1 is set exactly when a >= b (unsigned).
  assign borrow_n = c[8];

endmodule

// File: rtl/alu_op_sequencer.sv
// Single-issue ALU controller: one request in, sequenced to ADD/SUB/Booth MUL, one registered response out.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic                 req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  output logic                 busy,
  output alu_state_e           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // Valid never drops and payload never changes until that transfer; ready may be
  // any value. Only one operation is in flight, so req_ready is low outside IDLE.

  alu_state_e         state;
  alu_op_e            op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               cin_q;

  logic [7:0]         add_sum;
  logic               add_cout;
  logic [7:0]         sub_diff;
  logic               sub_borrow_n;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign req_ready = (state == ST_IDLE) && rst_n;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign mul_start = req_valid && req_ready && (req_op == OP_MUL);

  // Only WIDTH = 8 is meaningful while these fixed-width instances are used.
  ripple_carry_adder_8bit u_adder (
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  subtracter_8bit u_subtracter (
    .a        (a_q),
    .b        (b_q),
    .diff     (sub_diff),
    .borrow_n (sub_borrow_n)
  );

  booth_r2_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_booth (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .m       (req_a),
    .q       (req_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q  <= alu_op_e'(req_op);
            a_q   <= req_a;
            b_q   <= req_b;
            cin_q <= req_cin;
            state <= (req_op == OP_MUL) ? ST_MUL_RUN : ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_q)
            OP_ADD: begin
              rsp_result <= {{WIDTH{1'b0}}, add_sum};
              rsp_carry  <= add_cout;
              rsp_zero   <= (add_sum == '0);
              rsp_err    <= 1'b0;
            end
            OP_SUB: begin
              rsp_result <= {{WIDTH{1'b0}}, sub_diff};
              rsp_carry  <= sub_borrow_n;
              rsp_zero   <= (sub_diff == '0);
              rsp_err    <= 1'b0;
            end
            default: begin
              rsp_result <= '0;
              rsp_carry  <= 1'b0;
              rsp_zero   <= 1'b1;
              rsp_err    <= 1'b1;
            end
          endcase
          state <= ST_RESP;
        end
        ST_MUL_RUN: begin
          if (mul_done) begin
            rsp_result <= mul_product;
            rsp_carry  <= 1'b0;
            rsp_zero   <= (mul_product == '0);
            rsp_err    <= 1'b0;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Flags were captured on entry; valid is raised one edge later and held.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
